// File: rtl/display_scan_gen.sv
// Parametrised raster scan generator: H/V counters, syncs, data-enable, text-cell
// coordinates with per-frame vertical scroll, and a look-ahead fetch column.
module display_scan_gen #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned HSZ       = 10,
  parameter int unsigned VSZ       = 10,
  parameter int unsigned CELL_W    = 8,
  parameter int unsigned CELL_H    = 8,
  parameter bit          HS_POL    = 1'b0,
  parameter bit          VS_POL    = 1'b0,
  parameter int unsigned LOOKAHEAD = 2,
  localparam int unsigned CWB      = $clog2(CELL_W),
  localparam int unsigned CHB      = $clog2(CELL_H)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               ce_i,
  input  logic [VSZ-1:0]     scroll_y_i,
  output logic [HSZ-1:0]     hcount_o,
  output logic [VSZ-1:0]     vcount_o,
  output logic               de_o,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               sol_o,
  output logic               sof_o,
  output logic [CWB-1:0]     glyph_col_o,
  output logic [CHB-1:0]     glyph_row_o,
  output logic [HSZ-CWB-1:0] text_col_o,
  output logic [VSZ-CHB-1:0] text_row_o,
  output logic               fetch_de_o,
  output logic [HSZ-CWB-1:0] fetch_col_o,
  output logic [15:0]        frame_cnt_o
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HSZ-1:0] H_LAST = HSZ'(H_TOTAL - 1);
  localparam logic [VSZ-1:0] V_LAST = VSZ'(V_TOTAL - 1);
  localparam logic [HSZ:0]   HA_W   = (HSZ+1)'(H_ACTIVE);
  localparam logic [HSZ:0]   HS_BEG = (HSZ+1)'(H_ACTIVE + H_FP);
  localparam logic [HSZ:0]   HS_END = (HSZ+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HSZ:0]   LA_W   = (HSZ+1)'(LOOKAHEAD);
  localparam logic [VSZ:0]   VA_W   = (VSZ+1)'(V_ACTIVE);
  localparam logic [VSZ:0]   VS_BEG = (VSZ+1)'(V_ACTIVE + V_FP);
  localparam logic [VSZ:0]   VS_END = (VSZ+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [HSZ-CWB-1:0] FETCH_COL_RST = (HSZ-CWB)'(LOOKAHEAD / CELL_W);

  logic [HSZ-1:0] hcount_q, hcount_d;
  logic [VSZ-1:0] vcount_q, vcount_d;
  logic [VSZ-1:0] scroll_q, scroll_d;
  logic [15:0]    frame_q, frame_d;

  // Counter next-state; scroll is only sampled on frame wrap.
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    scroll_d = scroll_q;
    frame_d  = frame_q;
    if (ce_i) begin
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        if (vcount_q == V_LAST) begin
          vcount_d = '0;
          frame_d  = frame_q + 16'd1;
          scroll_d = ({1'b0, scroll_y_i} < VA_W) ? scroll_y_i : '0;
        end else begin
          vcount_d = vcount_q + VSZ'(1);
        end
      end else begin
        hcount_d = hcount_q + HSZ'(1);
      end
    end
  end

  logic [HSZ:0]       h_ext, hn;
  logic [VSZ:0]       v_ext, v_sum, v_eff;
  logic               h_act, v_act;
  logic               de_d, hsync_d, vsync_d, sol_d, sof_d, fetch_de_d;
  logic [CWB-1:0]     glyph_col_d;
  logic [CHB-1:0]     glyph_row_d;
  logic [HSZ-CWB-1:0] text_col_d, fetch_col_d;
  logic [VSZ-CHB-1:0] text_row_d;

  // Outputs are decoded from the next counter values so they register in step with them.
  always_comb begin
    h_ext       = {1'b0, hcount_d};
    v_ext       = {1'b0, vcount_d};
    hn          = h_ext + LA_W;
    h_act       = h_ext < HA_W;
    v_act       = v_ext < VA_W;
    v_sum       = v_ext + {1'b0, scroll_d};
    v_eff       = (v_sum >= VA_W) ? (v_sum - VA_W) : v_sum;
    de_d        = h_act && v_act;
    hsync_d     = (h_ext >= HS_BEG && h_ext < HS_END) ? HS_POL : ~HS_POL;
    vsync_d     = (v_ext >= VS_BEG && v_ext < VS_END) ? VS_POL : ~VS_POL;
    sol_d       = (hcount_d == '0);
    sof_d       = sol_d && (vcount_d == '0);
    glyph_col_d = h_act ? hcount_d[CWB-1:0] : '0;
    text_col_d  = h_act ? hcount_d[HSZ-1:CWB] : '0;
    glyph_row_d = v_act ? v_eff[CHB-1:0] : '0;
    text_row_d  = v_act ? v_eff[VSZ-1:CHB] : '0;
    fetch_de_d  = (hn < HA_W) && v_act;
    fetch_col_d = fetch_de_d ? hn[HSZ-1:CWB] : '0;
  end

  logic unused_veff_msb;
  assign unused_veff_msb = v_eff[VSZ];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hcount_q    <= '0;
      vcount_q    <= '0;
      scroll_q    <= '0;
      frame_q     <= '0;
      de_o        <= 1'b1;
      hsync_o     <= ~HS_POL;
      vsync_o     <= ~VS_POL;
      sol_o       <= 1'b1;
      sof_o       <= 1'b1;
      glyph_col_o <= '0;
      glyph_row_o <= '0;
      text_col_o  <= '0;
      text_row_o  <= '0;
      fetch_de_o  <= 1'b1;
      fetch_col_o <= FETCH_COL_RST;
    end else begin
      hcount_q    <= hcount_d;
      vcount_q    <= vcount_d;
      scroll_q    <= scroll_d;
      frame_q     <= frame_d;
      de_o        <= de_d;
      hsync_o     <= hsync_d;
      vsync_o     <= vsync_d;
      sol_o       <= sol_d;
      sof_o       <= sof_d;
      glyph_col_o <= glyph_col_d;
      glyph_row_o <= glyph_row_d;
      text_col_o  <= text_col_d;
      text_row_o  <= text_row_d;
      fetch_de_o  <= fetch_de_d;
      fetch_col_o <= fetch_col_d;
    end
  end

  assign hcount_o    = hcount_q;
  assign vcount_o    = vcount_q;
  assign frame_cnt_o = frame_q;

endmodule

// File: tb/tb_display_scan_gen.sv
// Bench for display_scan_gen: reference model of the raster rules checked every cycle,
// plus directed literal checks; a second instance covers 16x16 cells at 320x240.
module tb_display_scan_gen;

  localparam int HA = 640, HFP = 4, HSY = 8, HBP = 4, HT = HA + HFP + HSY + HBP;
  localparam int VA = 24, VFP = 2, VSY = 2, VBP = 2, VT = VA + VFP + VSY + VBP;
  localparam int CW = 8, CH = 8, LA = 2;

  logic clk = 1'b0;
  logic rst, rst2, ce;
  logic [9:0] scroll_y;

  logic [9:0] hcount, vcount;
  logic de, hsync, vsync, sol, sof, fetch_de;
  logic [2:0] glyph_col, glyph_row;
  logic [6:0] text_col, text_row, fetch_col;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  display_scan_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HSZ(10), .VSZ(10), .CELL_W(CW), .CELL_H(CH),
    .HS_POL(1'b0), .VS_POL(1'b0), .LOOKAHEAD(LA)
  ) dut (
    .clk_i(clk), .rst_i(rst), .ce_i(ce), .scroll_y_i(scroll_y),
    .hcount_o(hcount), .vcount_o(vcount), .de_o(de), .hsync_o(hsync), .vsync_o(vsync),
    .sol_o(sol), .sof_o(sof), .glyph_col_o(glyph_col), .glyph_row_o(glyph_row),
    .text_col_o(text_col), .text_row_o(text_row), .fetch_de_o(fetch_de),
    .fetch_col_o(fetch_col), .frame_cnt_o(frame_cnt)
  );

  logic [8:0] hcount2;
  logic [7:0] vcount2;
  logic de2, hsync2, vsync2, sol2, sof2, fetch_de2;
  logic [3:0] glyph_col2, glyph_row2, text_row2;
  logic [4:0] text_col2, fetch_col2;
  logic [15:0] frame_cnt2;

  display_scan_gen #(
    .H_ACTIVE(320), .H_FP(4), .H_SYNC(4), .H_BP(4),
    .V_ACTIVE(240), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .HSZ(9), .VSZ(8), .CELL_W(16), .CELL_H(16),
    .HS_POL(1'b0), .VS_POL(1'b0), .LOOKAHEAD(2)
  ) dut2 (
    .clk_i(clk), .rst_i(rst2), .ce_i(1'b1), .scroll_y_i(8'd0),
    .hcount_o(hcount2), .vcount_o(vcount2), .de_o(de2), .hsync_o(hsync2), .vsync_o(vsync2),
    .sol_o(sol2), .sof_o(sof2), .glyph_col_o(glyph_col2), .glyph_row_o(glyph_row2),
    .text_col_o(text_col2), .text_row_o(text_row2), .fetch_de_o(fetch_de2),
    .fetch_col_o(fetch_col2), .frame_cnt_o(frame_cnt2)
  );

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: raster position, latched scroll and frame count.
  int mh, mv, ms, mf;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mh <= 0; mv <= 0; ms <= 0; mf <= 0;
    end else if (ce) begin
      if (mh == HT - 1) begin
        mh <= 0;
        if (mv == VT - 1) begin
          mv <= 0;
          mf <= (mf + 1) % 65536;
          ms <= (int'(scroll_y) < VA) ? int'(scroll_y) : 0;
        end else begin
          mv <= mv + 1;
        end
      end else begin
        mh <= mh + 1;
      end
    end
  end

  always @(negedge clk) begin : compare
    int veff, hn;
    bit hact, vact, fde;
    if (!rst) begin
      hact = mh < HA;
      vact = mv < VA;
      veff = (mv + ms) % VA;
      hn   = mh + LA;
      fde  = (hn < HA) && vact;
      chk("hcount", int'(hcount), mh);
      chk("vcount", int'(vcount), mv);
      chk("de", int'(de), int'(hact && vact));
      chk("hsync", int'(hsync), (mh >= HA + HFP && mh < HA + HFP + HSY) ? 0 : 1);
      chk("vsync", int'(vsync), (mv >= VA + VFP && mv < VA + VFP + VSY) ? 0 : 1);
      chk("sol", int'(sol), int'(mh == 0));
      chk("sof", int'(sof), int'(mh == 0 && mv == 0));
      chk("glyph_col", int'(glyph_col), hact ? mh % CW : 0);
      chk("text_col", int'(text_col), hact ? mh / CW : 0);
      chk("glyph_row", int'(glyph_row), vact ? veff % CH : 0);
      chk("text_row", int'(text_row), vact ? veff / CH : 0);
      chk("fetch_de", int'(fetch_de), int'(fde));
      chk("fetch_col", int'(fetch_col), fde ? hn / CW : 0);
      chk("frame_cnt", int'(frame_cnt), mf);
    end
  end

  int mx_tc = 0, mx_tr = 0, mx_gc = 0, mx_gr = 0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst2) begin
      if (int'(text_col2) > mx_tc) mx_tc <= int'(text_col2);
      if (int'(text_row2) > mx_tr) mx_tr <= int'(text_row2);
      if (int'(glyph_col2) > mx_gc) mx_gc <= int'(glyph_col2);
      if (int'(glyph_row2) > mx_gr) mx_gr <= int'(glyph_row2);
    end
  end

  task automatic wait_pos(input int h, input int v);
    bit found = 1'b0;
    for (int k = 0; k < 30000; k++) begin
      if (mh == h && mv == v) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("wait_pos_reached", int'(found), 1);
  endtask

  initial begin
    int de_n, sof_n;
    rst = 1'b1; rst2 = 1'b1; ce = 1'b0; scroll_y = '0;
    repeat (3) @(negedge clk);
    chk("rst_hcount", int'(hcount), 0);
    chk("rst_de", int'(de), 1);
    chk("rst_sof", int'(sof), 1);
    chk("rst_hsync", int'(hsync), 1);
    chk("rst_vsync", int'(vsync), 1);
    chk("rst_fetch_de", int'(fetch_de), 1);
    chk("rst_fetch_col", int'(fetch_col), 0);
    rst = 1'b0; rst2 = 1'b0; ce = 1'b1;

    // Frame 0: free-running, directed literal points.
    de_n = 0;
    for (int i = 0; i < HT * VT; i++) begin
      if (de) de_n++;
      if (i == 1) chk("sof_one_cycle", int'(sof), 0);
      if (i == HT) scroll_y = 10'd600;
      if (i == 637) begin
        chk("fetch_col_637", int'(fetch_col), 79);
        chk("fetch_de_637", int'(fetch_de), 1);
      end
      if (i == 638) begin
        chk("fetch_de_638", int'(fetch_de), 0);
        chk("text_col_638", int'(text_col), 79);
        chk("glyph_col_638", int'(glyph_col), 6);
      end
      if (i == 643) chk("hsync_643", int'(hsync), 1);
      if (i == 644) chk("hsync_644", int'(hsync), 0);
      if (i == 651) chk("hsync_651", int'(hsync), 0);
      if (i == 652) chk("hsync_652", int'(hsync), 1);
      if (i == 25 * HT + 5) chk("vsync_v25", int'(vsync), 1);
      if (i == 26 * HT) chk("vsync_v26", int'(vsync), 0);
      if (i == 27 * HT + HT - 1) chk("vsync_v27", int'(vsync), 0);
      if (i == 28 * HT) chk("vsync_v28", int'(vsync), 1);
      if (i == HT * VT - 1) chk("frame_cnt_end0", int'(frame_cnt), 0);
      @(negedge clk);
    end
    chk("de_per_frame", de_n, 640 * 24);
    chk("frame_cnt_1", int'(frame_cnt), 1);
    chk("f1_sof", int'(sof), 1);
    chk("f1_glyph_row_scroll600", int'(glyph_row), 0);

    // Frame 1: scroll_lat is 0; a new scroll value written mid-frame must not apply.
    for (int i = 0; i < HT * VT; i++) begin
      if (i == 2 * HT) scroll_y = 10'd5;
      if (i == 5 * HT) chk("f1_glyph_row_v5", int'(glyph_row), 5);
      if (i == 8 * HT) begin
        chk("f1_text_row_v8", int'(text_row), 1);
        chk("f1_glyph_row_v8", int'(glyph_row), 0);
      end
      @(negedge clk);
    end

    // Frame 2 start: scroll 5 latched; ce now 1-of-4.
    sof_n = 0;
    for (int j = 0; j < 4 * HT + 4; j++) begin
      if (j == 0) begin
        chk("f2_glyph_row_v0", int'(glyph_row), 5);
        chk("f2_text_row_v0", int'(text_row), 0);
        chk("f2_frame_cnt", int'(frame_cnt), 2);
      end
      if (j < 8 && sof) sof_n++;
      ce = (j % 4 == 3);
      @(negedge clk);
    end
    chk("sof_held_ce4", sof_n, 4);
    ce = 1'b1;

    wait_pos(0, 3);
    chk("f2_text_row_v3", int'(text_row), 1);
    chk("f2_glyph_row_v3", int'(glyph_row), 0);
    wait_pos(0, 18);
    chk("f2_glyph_row_v18", int'(glyph_row), 7);
    chk("f2_text_row_v18", int'(text_row), 2);
    wait_pos(0, 19);
    chk("f2_glyph_row_v19", int'(glyph_row), 0);
    chk("f2_text_row_v19", int'(text_row), 0);

    // Mid-frame asynchronous reset pulse.
    wait_pos(300, 20);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_hcount", int'(hcount), 0);
    chk("arst_vcount", int'(vcount), 0);
    chk("arst_sof", int'(sof), 1);
    chk("arst_de", int'(de), 1);
    chk("arst_frame_cnt", int'(frame_cnt), 0);
    chk("arst_glyph_row", int'(glyph_row), 0);
    chk("arst_fetch_col", int'(fetch_col), 0);
    #1 rst = 1'b0;
    repeat (HT + 3) @(negedge clk);

    // Second instance: covers one full active field of 320x240 with 16x16 cells.
    while (cyc < 240 * 332 + 20) @(negedge clk);
    chk("c16_text_col_max", mx_tc, 19);
    chk("c16_text_row_max", mx_tr, 14);
    chk("c16_glyph_col_max", mx_gc, 15);
    chk("c16_glyph_row_max", mx_gr, 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scan_gen.md
Name: display_scan_gen

Overview:
- Parametrised successor to the fixed 640x480 scan logic in the graphics generator.
- Generates H/V timing, sync and data-enable, plus text-cell coordinates: glyph column/row and text column/row.
- Adds three things the fixed logic lacks:
  - a pixel clock-enable, so the block runs on one system clock;
  - per-frame latched vertical fine scroll with wrap;
  - a look-ahead fetch coordinate, so text RAM and glyph ROM pipelines can prefetch.
- Sits between the system clock domain and the text/graphics pixel pipelines.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, active lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
HSZ, 10, hcount width; must hold H_TOTAL-1
VSZ, 10, vcount width; must hold V_TOTAL-1
CELL_W, 8, glyph width in pixels; power of two
CELL_H, 8, glyph height in lines; power of two
HS_POL, 0, hsync asserted level
VS_POL, 0, vsync asserted level
LOOKAHEAD, 2, prefetch distance in pixels, 0..CELL_W

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous reset, active-high
ce_i  in  1  pixel clock enable; the block advances one pixel per cycle with ce_i=1
scroll_y_i  in  VSZ  vertical scroll in lines; sampled at frame wrap
hcount_o  out  HSZ  current pixel column, 0..H_TOTAL-1
vcount_o  out  VSZ  current line, 0..V_TOTAL-1
de_o  out  1  active video
hsync_o  out  1  horizontal sync
vsync_o  out  1  vertical sync
sol_o  out  1  start of line (hcount=0)
sof_o  out  1  start of frame (hcount=0, vcount=0)
glyph_col_o  out  log2(CELL_W)  pixel within cell
glyph_row_o  out  log2(CELL_H)  line within cell, scrolled
text_col_o  out  HSZ-log2(CELL_W)  cell column
text_row_o  out  VSZ-log2(CELL_H)  cell row, scrolled
fetch_de_o  out  1  look-ahead pixel is active
fetch_col_o  out  HSZ-log2(CELL_W)  cell column of pixel hcount+LOOKAHEAD
frame_cnt_o  out  16  frames completed, wraps modulo 2^16

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- All outputs are registered and are a pure function of the registered (hcount, vcount, scroll_lat) in the same cycle. No output lags the counters.
- ce_i=0: every register holds. ce_i=1: hcount increments.
  - hcount = H_TOTAL-1 wraps to 0 and increments vcount.
  - vcount = V_TOTAL-1 also wraps vcount to 0 (frame wrap).
- Reset (async, any time, including mid-line):
  - hcount=vcount=0, scroll_lat=0, frame_cnt_o=0.
  - Decoded outputs are immediately consistent with (0,0): de_o=1, sol_o=1, sof_o=1, fetch_de_o=1, glyph/text outputs 0, fetch_col_o=LOOKAHEAD/CELL_W.
  - hsync_o=~HS_POL, vsync_o=~VS_POL.
- de_o = (hcount<H_ACTIVE) && (vcount<V_ACTIVE).
- hsync_o = HS_POL when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL. vsync_o uses the same rule on vcount with V parameters.
- sol_o and sof_o: high for exactly one ce period. Both are held, not re-pulsed, while ce_i=0.
- Frame wrap:
  - frame_cnt_o increments.
  - scroll_lat <= scroll_y_i if scroll_y_i < V_ACTIVE, else 0.
  - Mid-frame changes to scroll_y_i have no effect.
- Horizontal cell coordinates: glyph_col_o = hcount mod CELL_W and text_col_o = hcount / CELL_W while hcount < H_ACTIVE; both 0 otherwise.
- Vertical cell coordinates, active lines (vcount < V_ACTIVE):
  - v_eff = vcount + scroll_lat, minus V_ACTIVE if the sum >= V_ACTIVE (wrap).
  - glyph_row_o = v_eff mod CELL_H; text_row_o = v_eff / CELL_H.
  - In vertical blanking both are 0.
- Look-ahead: let hn = hcount+LOOKAHEAD.
  - fetch_de_o = (hn<H_ACTIVE) && (vcount<V_ACTIVE).
  - fetch_col_o = hn/CELL_W when fetch_de_o, else 0.
  - Effect: a consumer with LOOKAHEAD-cycle latency presents data aligned with de_o.
- Arithmetic: unsigned. The scroll add is performed at VSZ+1 bits before the compare, so no overflow.

Test Plan:
1. Reset, ce_i=1 constant, default params -> hsync_o low for hcount 656..751; vsync_o low for vcount 490..491; de_o high for exactly 640x480 cycles per 800x525-cycle frame; frame_cnt_o=1 after 420000 cycles.
2. ce_i toggling 1-of-4 -> counts advance every 4th cycle; sof_o stays high for the 4 cycles at (0,0); all outputs are identical to test 1 when sampled at ce_i=1.
3. scroll_y_i=5 set mid-frame 0 -> no change in frame 0. Frame 1, vcount=0: glyph_row_o=5, text_row_o=0. vcount=475: v_eff=0, so glyph_row_o=0, text_row_o=0. scroll_y_i=600 -> scroll_lat=0.
4. hcount=637, LOOKAHEAD=2 -> fetch_col_o=79, fetch_de_o=1. hcount=638 -> fetch_de_o=0, text_col_o=79, glyph_col_o=6.
5. Assert rst_i at (hcount=300, vcount=200) for half a cycle -> immediately hcount=vcount=0, sof_o=1, frame_cnt_o=0, scroll_lat=0.
6. Params CELL_W=16, CELL_H=16, H_ACTIVE=320, V_ACTIVE=240 with matching porches -> text_col_o max 19, text_row_o max 14, glyph_col_o max 15.
